rv_muldiv_seq: RTL

RV_MULDIV_SEQ -- requirements
Module: rv_muldiv_seq

---
 rtl/rv_muldiv_seq_pkg.sv | 50 +++++
 rtl/rv_div_special.sv | 41 ++++
 rtl/rv_muldiv_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rv_muldiv_seq_pkg.sv
// ============================================================
// pkg_rv_decode : ALU opcodes, mul/div sequencer states, constants
// Rev 1.0
// ============================================================
`default_nettype none

package pkg_rv_decode;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic is_mul_op(input alu_t op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction

  function automatic logic is_div_op(input alu_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_div_special.sv
// ============================================================
// rv_div_special : zero-divisor / signed-overflow detection and result
// Rev 1.0
// ============================================================
`default_nettype none

module rv_div_special
  import pkg_rv_decode::*;
(
  input  alu_t        alu,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        is_div,
  output logic        bypass,
  output logic [31:0] bypass_res
);

  logic is_signed;
  logic is_rem;
  logic div_zero;
  logic sgn_ovf;

  always_comb begin
    is_div     = is_div_op(alu);
    is_signed  = (alu == ALU_DIV) || (alu == ALU_REM);
    is_rem     = (alu == ALU_REM) || (alu == ALU_REMU);
    div_zero   = is_div && (rs2 == 32'd0);
    sgn_ovf    = is_signed && (rs1 == INT_MIN) && (rs2 == 32'hFFFF_FFFF);
    bypass     = div_zero || sgn_ovf;
    bypass_res = 32'd0;
    // Zero divisor takes priority; the two cases cannot overlap anyway.
    if (div_zero) begin
      bypass_res = is_rem ? rs1 : DIV_ZERO_Q;
    end else if (sgn_ovf) begin
      bypass_res = is_rem ? 32'd0 : INT_MIN;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv_muldiv_seq.sv
// ============================================================
// rv_muldiv_seq : sequences M-extension ops between EX and the mul/div unit
// Rev 1.0
// ============================================================
`default_nettype none

module rv_muldiv_seq
  import pkg_rv_decode::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  alu_t        ex_alu,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic        flush,
  output logic        stall,
  output alu_t        md_alu,
  output logic [31:0] md_rrd1,
  output logic [31:0] md_rrd2,
  output logic        md_rdy,
  input  logic [31:0] md_rwdat,
  input  logic [31:0] md_rwdatx,
  input  logic        md_cmpl,
  input  logic        md_mulop,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_dat,
  output logic        busy
);

  md_state_t   state_q, state_d;
  logic        orphan_q, orphan_d;
  alu_t        alu_q, alu_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;

  logic        sp_is_div;
  logic        sp_bypass;
  logic [31:0] sp_res;
  logic        is_mul;
  logic        div_cmpl;
  logic        offer;

  rv_div_special u_div_special (
    .alu        (ex_alu),
    .rs1        (ex_rs1),
    .rs2        (ex_rs2),
    .is_div     (sp_is_div),
    .bypass     (sp_bypass),
    .bypass_res (sp_res)
  );

  always_comb begin
    state_d  = state_q;
    orphan_d = orphan_q;
    alu_d    = alu_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    res_d    = res_q;
    stall    = 1'b0;
    md_rdy   = 1'b0;
    wb_valid = 1'b0;
    is_mul   = is_mul_op(ex_alu);
    // Strobes flagged as multiply-side are not divide completions.
    div_cmpl = md_cmpl && !md_mulop;
    offer    = ex_valid && !flush && !reset;

    if (div_cmpl) begin
      orphan_d = 1'b0;
    end

    case (state_q)
      MD_IDLE: begin
        if (offer && (is_mul || sp_is_div)) begin
          stall = 1'b1;
          // A divide must wait while an abandoned divide still occupies the unit.
          if (is_mul || !orphan_q) begin
            alu_d = ex_alu;
            rs1_d = ex_rs1;
            rs2_d = ex_rs2;
            rd_d  = ex_rd;
            if (is_mul) begin
              state_d = MD_MUL;
            end else if (sp_bypass) begin
              res_d   = sp_res;
              state_d = MD_DONE;
            end else begin
              md_rdy  = 1'b1;
              state_d = MD_DIV;
            end
          end
        end
      end
      MD_MUL: begin
        wb_valid = !flush;
        state_d  = MD_IDLE;
      end
      MD_DIV: begin
        stall = 1'b1;
        if (flush) begin
          orphan_d = !div_cmpl;
          state_d  = MD_IDLE;
        end else if (div_cmpl) begin
          res_d   = md_rwdat;
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        wb_valid = !flush;
        state_d  = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      orphan_q <= 1'b0;
      alu_q    <= ALU_ADD;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      rd_q     <= 5'd0;
      res_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      orphan_q <= orphan_d;
      alu_q    <= alu_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    md_alu  = (state_q == MD_IDLE) ? ex_alu : alu_q;
    md_rrd1 = (state_q == MD_IDLE) ? ex_rs1 : rs1_q;
    md_rrd2 = (state_q == MD_IDLE) ? ex_rs2 : rs2_q;
    wb_rd   = rd_q;
    wb_dat  = (state_q == MD_MUL) ? md_rwdatx : res_q;
    busy    = (state_q != MD_IDLE) || orphan_q;
  end

endmodule

`default_nettype wire
